// File: rtl/timer_nch.sv
// timer_nch: N-channel down-counting timer with a memory-mapped register file.
// Each channel counts synchronised rising edges of its own tick input and runs
// in one-shot, periodic-pulse or square-wave mode. A terminal event sets a
// sticky done flag, and done flags gated by IE are combined into one irq line.
module timer_nch #(
    parameter int NCH   = 3,
    parameter int WIDTH = 32,
    localparam int CSW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic [NCH-1:0]   tick,
    input  logic             we,
    input  logic [CSW-1:0]   ch_sel,
    input  logic [1:0]       reg_sel,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic [NCH-1:0]   ch_out,
    output logic             irq
);

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_SQUARE   = 2'b10,
        MODE_RESERVED = 2'b11
    } mode_e;

    localparam logic [1:0] REG_RELOAD = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [NCH-1:0]            sync1;
    logic [NCH-1:0]            sync2;
    logic [NCH-1:0]            sync3;
    logic [2:0]                arm;
    logic [NCH-1:0]            step;
    logic                      wr_status;

    logic [NCH-1:0][WIDTH-1:0] reload_v;
    logic [NCH-1:0][WIDTH-1:0] count_v;
    logic [NCH-1:0][3:0]       ctrl_v;
    logic [NCH-1:0]            done_v;
    logic [NCH-1:0]            ie_v;

    // Two-FF synchroniser for the asynchronous tick inputs, plus an edge register.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= tick;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Arming shift register: edge detection is held off until the edge register
    // has captured a real synchronised sample, so a tick held high through reset
    // never looks like a rising edge.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            arm <= '0;
        end else begin
            arm <= {arm[1:0], 1'b1};
        end
    end

    assign step      = arm[2] ? (sync2 & ~sync3) : '0;
    assign wr_status = we && (reg_sel == REG_STATUS);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [WIDTH-1:0] reload_q;
        logic [WIDTH-1:0] count_q;
        logic [1:0]       mode_q;
        logic             en_q;
        logic             ie_q;
        logic             out_q;
        logic             done_q;
        logic             hit;
        logic             wr_reload;
        logic             wr_ctrl;
        logic             terminal;
        mode_e            eff_mode;

        assign hit       = (ch_sel == CSW'(i));
        assign wr_reload = we && hit && (reg_sel == REG_RELOAD);
        assign wr_ctrl   = we && hit && (reg_sel == REG_CTRL);
        assign eff_mode  = (mode_q == MODE_RESERVED) ? MODE_ONESHOT : mode_e'(mode_q);
        // A CTRL write on this channel swallows a coincident step.
        assign terminal  = step[i] && en_q && (count_q == '0) && !wr_ctrl;

        // Reload register; a coincident reload event still sees the old value.
        always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN) begin
                reload_q <= '0;
            end else if (wr_reload) begin
                reload_q <= wdata[WIDTH-1:0];
            end
        end

        // Control register; a one-shot terminal event turns the channel off.
        always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN) begin
                en_q   <= 1'b0;
                mode_q <= 2'b00;
                ie_q   <= 1'b0;
            end else if (wr_ctrl) begin
                en_q   <= wdata[0];
                mode_q <= wdata[2:1];
                ie_q   <= wdata[3];
            end else if (terminal && (eff_mode == MODE_ONESHOT)) begin
                en_q   <= 1'b0;
            end
        end

        // Down counter and channel output; periodic pulses self-clear after one clk.
        always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN) begin
                count_q <= '0;
                out_q   <= 1'b0;
            end else if (wr_ctrl) begin
                if (wdata[0]) begin
                    count_q <= reload_q;
                    out_q   <= 1'b0;
                end
            end else if (terminal) begin
                case (eff_mode)
                    MODE_PERIODIC: begin
                        count_q <= reload_q;
                        out_q   <= 1'b1;
                    end
                    MODE_SQUARE: begin
                        count_q <= reload_q;
                        out_q   <= ~out_q;
                    end
                    default: begin
                        out_q   <= 1'b1;
                    end
                endcase
            end else begin
                if (step[i] && en_q) begin
                    count_q <= count_q - WIDTH'(1);
                end
                if (en_q && (eff_mode == MODE_PERIODIC)) begin
                    out_q <= 1'b0;
                end
            end
        end

        // Sticky done flag; a new terminal event wins over a same-cycle W1C clear.
        always_ff @(posedge clk or negedge RSTN) begin
            if (!RSTN) begin
                done_q <= 1'b0;
            end else if (terminal) begin
                done_q <= 1'b1;
            end else if (wr_status && wdata[i]) begin
                done_q <= 1'b0;
            end
        end

        assign reload_v[i] = reload_q;
        assign count_v[i]  = count_q;
        assign ctrl_v[i]   = {ie_q, mode_q, en_q};
        assign done_v[i]   = done_q;
        assign ie_v[i]     = ie_q;
        assign ch_out[i]   = out_q;
    end

    // Registered interrupt: any channel with done and IE both set.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            irq <= 1'b0;
        end else begin
            irq <= |(done_v & ie_v);
        end
    end

    // Read mux; unselected or out-of-range channels read as zero.
    always_comb begin
        rdata = '0;
        if (reg_sel == REG_STATUS) begin
            rdata[NCH-1:0]   = done_v;
            rdata[16 +: NCH] = ch_out;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_sel == CSW'(i)) begin
                    case (reg_sel)
                        REG_RELOAD: rdata[WIDTH-1:0] = reload_v[i];
                        REG_CTRL:   rdata[3:0]       = ctrl_v[i];
                        REG_COUNT:  rdata[WIDTH-1:0] = count_v[i];
                        default:    rdata            = '0;
                    endcase
                end
            end
        end
    end

endmodule
